wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares NUM_WB register-file write-back ports among NUM_FUS functional-unit result streams.
- Each FU has a one-entry hold register; stalled FUs are back-pressured through a valid/ready handshake.
- Granted entries drive the RF write ports and the per-port valid/dst/value fields consumed by the forwarding unit.
- Sits between the execute-stage FUs and the register file / forwarding network.

Parameters:
- NUM_FUS, 4: number of result requesters.
- NUM_WB, 2: number of RF write ports; 1 <= NUM_WB <= NUM_FUS.
- XLEN, 32: data width.
- REG_AW, 5: architectural register index width.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held results.
- fu_valid  in  [NUM_FUS]  FU presents a result.
- fu_dst  in  [NUM_FUS][REG_AW]  destination register.
- fu_val  in  [NUM_FUS][XLEN]  result value.
- fu_ready  out  [NUM_FUS]  FU result accepted this cycle.
- wb_valid  out  [NUM_WB]  write port active; also the forwarding valid.
- wb_dst  out  [NUM_WB][REG_AW]  write destination.
- wb_val  out  [NUM_WB][XLEN]  write data.
- wb_fu_id  out  [NUM_WB][$clog2(NUM_FUS)]  source FU, for debug and scoreboard release.

Behaviour:
- Reset (async, rst_n=0):
  - All hold valids = 0; rr_ptr = 0.
  - wb_valid = 0; wb_dst, wb_val and wb_fu_id = 0.
  - fu_ready = 0 while rst_n = 0.
- Hold register per FU i:
  - Contents: held[i], hdst[i], hval[i].
  - Handshake: a transfer occurs when fu_valid[i] && fu_ready[i] at a rising edge.
  - fu_ready[i] = !flush && (!held[i] || grant[i]). This is full throughput: a granted entry is replaced in the same cycle.
- x0 results:
  - A result with fu_dst == 0 is accepted under the same ready rule but never sets held[i].
  - It never consumes a port.
- Latency:
  - A result accepted at edge N is eligible for grant in cycle N+1.
  - There is no combinational path from fu_* to wb_*.
- Grant (combinational from hold registers):
  - Scan FUs in circular order starting at rr_ptr.
  - Grant up to NUM_WB held entries.
  - Port k takes the k-th granted entry in scan order. Unused ports have wb_valid = 0 and zeroed dst/val/fu_id.
- Same-destination rule:
  - If a held entry's hdst equals the hdst of an entry already granted this cycle, skip it.
  - The skipped entry is retried next cycle. Two ports never write the same register in one cycle.
- Round-robin update:
  - If any grant is made, rr_ptr <= (index of last granted FU + 1) mod NUM_FUS.
  - Otherwise rr_ptr holds. Wrap-around is at NUM_FUS-1 -> 0.
- Hold update:
  - On grant without a new transfer, held[i] <= 0.
  - On a new transfer (dst != 0), load hdst/hval and set held[i] <= 1.
- Flush:
  - All held[i] <= 0 at the next edge.
  - During the flush cycle: wb_valid = 0, fu_ready = 0, rr_ptr unchanged.
- Starvation bound: any held entry is granted within ceil(NUM_FUS/NUM_WB) cycles, absent dst conflicts and flush.
- Reset mid-operation: all held results are lost immediately; there is no partial write.

Decomposition:
- Shared backend package:
  - Params: NUM_FUS, NUM_WB, XLEN, REG_AW.
  - Typedef reg_idx_t.
  - Typedef wb_pkt_t {valid, dst, val, fu_id}; wb_* ports may be packed as wb_pkt_t[NUM_WB].
- Sub-module rr_multi_picker:
  - Purely combinational.
  - Inputs: request vector, dst vector, rr_ptr.
  - Outputs: per-port one-hot grant and next rr_ptr.
  - Reusable by a future issue scheduler.

Test Plan:
1. Reset release, single result: FU1 presents dst=5, val=0xDEADBEEF one cycle -> fu_ready[1]=1 that cycle. Next cycle wb_valid[0]=1, wb_dst[0]=5, wb_val[0]=0xDEADBEEF, wb_fu_id[0]=1, wb_valid[1]=0. Then rr_ptr=2.
2. Port contention: all 4 FUs hold results (dst 1,2,3,4) with rr_ptr=0, no new input -> cycle 1 grants FU0,FU1; cycle 2 grants FU2,FU3. fu_ready stays 1 only for granted FUs. rr_ptr sequence 0->2->0.
3. Continuous back-pressure fairness: all FUs assert valid every cycle for 40 cycles -> each FU gets exactly 20 grants, and no FU waits more than 2 cycles.
4. Same-destination conflict: FU0 and FU1 both hold dst=7, vals 0x11/0x22, rr_ptr=0 -> cycle 1 writes only 0x11 and the second port stays idle (no other held). Cycle 2 writes 0x22.
5. x0 and flush: FU2 sends dst=0 -> accepted, no wb_valid. Then 3 FUs held and flush=1 -> wb_valid=0 and fu_ready=0 that cycle. All holds are empty next cycle and rr_ptr is unchanged.
6. Async reset mid-stream: assert rst_n=0 between edges with entries held -> wb_valid drops to 0 immediately without waiting for clk. After release, no stale write appears.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared back-end definitions for the write-back arbiter: sizing constants,
// register index / FU id types and the per-port write-back packet.
package wb_arbiter_pkg;

  localparam int NUM_FUS = 4;
  localparam int NUM_WB  = 2;
  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int FU_IDW  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [FU_IDW-1:0] fu_id_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        dst;
    logic [XLEN-1:0] val;
    fu_id_t          fu_id;
  } wb_pkt_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Combinational round-robin picker granting up to NUM_PORTS requesters per
// cycle, never granting two requesters with the same destination together.
module rr_multi_picker #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int DST_W     = 5,
  parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][DST_W-1:0]       dst,
  input  logic [IDW-1:0]                      rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0]   port_grant,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [IDW-1:0]                      next_ptr
);

  logic [NUM_PORTS-1:0][DST_W-1:0] gdst;
  logic [IDW-1:0]                  idx;
  logic                            conflict;
  int                              cnt;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk requesters once in circular order; port k receives the k-th winner.
  always_comb begin
    port_grant = '0;
    grant      = '0;
    next_ptr   = rr_ptr;
    gdst       = '0;
    idx        = rr_ptr;
    conflict   = 1'b0;
    cnt        = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      conflict = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (k < cnt && gdst[k] == dst[idx]) begin
          conflict = 1'b1;
        end
      end
      if (req[idx] && cnt < NUM_PORTS && !conflict) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (k == cnt) begin
            port_grant[k][idx] = 1'b1;
            gdst[k]            = dst[idx];
          end
        end
        grant[idx] = 1'b1;
        next_ptr   = wrap_inc(idx);
        cnt        = cnt + 1;
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one hold register per functional unit, shared among
// NUM_WB register-file write ports by a round-robin picker.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [NUM_FUS-1:0]               fu_valid,
  input  logic [NUM_FUS-1:0][REG_AW-1:0]   fu_dst,
  input  logic [NUM_FUS-1:0][XLEN-1:0]     fu_val,
  output logic [NUM_FUS-1:0]               fu_ready,
  output logic [NUM_WB-1:0]                wb_valid,
  output logic [NUM_WB-1:0][REG_AW-1:0]    wb_dst,
  output logic [NUM_WB-1:0][XLEN-1:0]      wb_val,
  output logic [NUM_WB-1:0][FU_IDW-1:0]    wb_fu_id
);

  logic [NUM_FUS-1:0]                held;
  reg_idx_t [NUM_FUS-1:0]            hdst;
  logic [NUM_FUS-1:0][XLEN-1:0]      hval;
  fu_id_t                            rr_ptr;

  logic [NUM_FUS-1:0]                req;
  logic [NUM_FUS-1:0]                grant;
  logic [NUM_WB-1:0][NUM_FUS-1:0]    port_grant;
  fu_id_t                            next_ptr;
  wb_pkt_t [NUM_WB-1:0]              pkt;

  // A flush suppresses every grant, which also keeps rr_ptr where it is.
  assign req = flush ? '0 : held;

  rr_multi_picker #(
    .NUM_REQ   (NUM_FUS),
    .NUM_PORTS (NUM_WB),
    .DST_W     (REG_AW),
    .IDW       (FU_IDW)
  ) u_picker (
    .req        (req),
    .dst        (hdst),
    .rr_ptr     (rr_ptr),
    .port_grant (port_grant),
    .grant      (grant),
    .next_ptr   (next_ptr)
  );

  // A granted slot frees up this cycle, so it can accept a replacement.
  assign fu_ready = (rst_n && !flush) ? (~held | grant) : '0;

  always_comb begin
    pkt = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (port_grant[k][i]) begin
          pkt[k].valid = 1'b1;
          pkt[k].dst   = hdst[i];
          pkt[k].val   = hval[i];
          pkt[k].fu_id = FU_IDW'(i);
        end
      end
    end
  end

  always_comb begin
    wb_valid = '0;
    wb_dst   = '0;
    wb_val   = '0;
    wb_fu_id = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_valid[k] = pkt[k].valid;
      wb_dst[k]   = pkt[k].dst;
      wb_val[k]   = pkt[k].val;
      wb_fu_id[k] = pkt[k].fu_id;
    end
  end

  // Results to x0 complete the handshake but are dropped instead of held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held   <= '0;
      hdst   <= '0;
      hval   <= '0;
      rr_ptr <= '0;
    end else begin
      rr_ptr <= next_ptr;
      for (int i = 0; i < NUM_FUS; i++) begin
        if (flush) begin
          held[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          held[i] <= (fu_dst[i] != '0);
          if (fu_dst[i] != '0) begin
            hdst[i] <= fu_dst[i];
            hval[i] <= fu_val[i];
          end
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// cycle's write-back and ready outputs; a negedge monitor compares them.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             flush;
  logic [NUM_FUS-1:0]               fu_valid;
  logic [NUM_FUS-1:0][REG_AW-1:0]   fu_dst;
  logic [NUM_FUS-1:0][XLEN-1:0]     fu_val;
  logic [NUM_FUS-1:0]               fu_ready;
  logic [NUM_WB-1:0]                wb_valid;
  logic [NUM_WB-1:0][REG_AW-1:0]    wb_dst;
  logic [NUM_WB-1:0][XLEN-1:0]      wb_val;
  logic [NUM_WB-1:0][FU_IDW-1:0]    wb_fu_id;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_dst   (fu_dst),
    .fu_val   (fu_val),
    .fu_ready (fu_ready),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst),
    .wb_val   (wb_val),
    .wb_fu_id (wb_fu_id)
  );

  typedef struct {
    logic [NUM_WB-1:0]                v;
    logic [NUM_WB-1:0][REG_AW-1:0]    dst;
    logic [NUM_WB-1:0][XLEN-1:0]      val;
    logic [NUM_WB-1:0][FU_IDW-1:0]    id;
    logic [NUM_FUS-1:0]               rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference state: which FUs hold a result, its contents, and the scan start.
  bit              m_held[NUM_FUS];
  logic [REG_AW-1:0] m_dst[NUM_FUS];
  logic [XLEN-1:0] m_val[NUM_FUS];
  int              m_rr;

  bit count_en = 1'b0;
  int grant_cnt[NUM_FUS];

  logic [NUM_FUS-1:0][REG_AW-1:0] d;
  logic [NUM_FUS-1:0][XLEN-1:0]   x;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_FUS; i++) begin
      m_held[i] = 1'b0;
      m_dst[i]  = '0;
      m_val[i]  = '0;
    end
    m_rr = 0;
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic applyStimulus(input logic [NUM_FUS-1:0] v,
                               input logic [NUM_FUS-1:0][REG_AW-1:0] dd,
                               input logic [NUM_FUS-1:0][XLEN-1:0] xx,
                               input logic f);
    exp_t e;
    int   gl[$];
    bit   g[NUM_FUS];
    bit   dup;
    int   idx;
    fu_valid = v;
    fu_dst   = dd;
    fu_val   = xx;
    flush    = f;
    e.v = '0; e.dst = '0; e.val = '0; e.id = '0; e.rdy = '0;
    for (int i = 0; i < NUM_FUS; i++) g[i] = 1'b0;
    if (!f) begin
      for (int j = 0; j < NUM_FUS; j++) begin
        idx = (m_rr + j) % NUM_FUS;
        if (m_held[idx] && gl.size() < NUM_WB) begin
          dup = 1'b0;
          foreach (gl[n]) if (m_dst[gl[n]] == m_dst[idx]) dup = 1'b1;
          if (!dup) gl.push_back(idx);
        end
      end
    end
    foreach (gl[n]) begin
      e.v[n]   = 1'b1;
      e.dst[n] = m_dst[gl[n]];
      e.val[n] = m_val[gl[n]];
      e.id[n]  = FU_IDW'(gl[n]);
      g[gl[n]] = 1'b1;
    end
    for (int i = 0; i < NUM_FUS; i++) e.rdy[i] = !f && (!m_held[i] || g[i]);
    exp_q.push_back(e);
    for (int i = 0; i < NUM_FUS; i++) begin
      if (f) begin
        m_held[i] = 1'b0;
      end else if (v[i] && e.rdy[i]) begin
        m_held[i] = (dd[i] != '0);
        if (dd[i] != '0) begin
          m_dst[i] = dd[i];
          m_val[i] = xx[i];
        end
      end else if (g[i]) begin
        m_held[i] = 1'b0;
      end
    end
    if (gl.size() > 0) m_rr = (gl[gl.size() - 1] + 1) % NUM_FUS;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus('0, '0, '0, 1'b0);
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("fu_ready", 64'(fu_ready), 64'(mon_e.rdy));
      for (int k = 0; k < NUM_WB; k++) begin
        checkOutput($sformatf("wb_valid[%0d]", k), 64'(wb_valid[k]), 64'(mon_e.v[k]));
        checkOutput($sformatf("wb_dst[%0d]", k), 64'(wb_dst[k]), 64'(mon_e.dst[k]));
        checkOutput($sformatf("wb_val[%0d]", k), 64'(wb_val[k]), 64'(mon_e.val[k]));
        checkOutput($sformatf("wb_fu_id[%0d]", k), 64'(wb_fu_id[k]), 64'(mon_e.id[k]));
        if (count_en && wb_valid[k]) grant_cnt[wb_fu_id[k]]++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    fu_valid = '0; fu_dst = '0; fu_val = '0;
    modelReset();
    for (int i = 0; i < NUM_FUS; i++) grant_cnt[i] = 0;

    #2;
    fu_valid = '1;
    checkOutput("reset_fu_ready", 64'(fu_ready), 64'd0);
    checkOutput("reset_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("reset_wb_dst", 64'(wb_dst), 64'd0);
    checkOutput("reset_wb_val", 64'(wb_val), 64'd0);
    checkOutput("reset_wb_fu_id", 64'(wb_fu_id), 64'd0);
    fu_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single result from FU1");
    d = '0; x = '0; d[1] = 5; x[1] = 32'hDEADBEEF;
    applyStimulus(4'b0010, d, x, 1'b0);
    checkOutput("t1_wb_valid0", 64'(wb_valid[0]), 64'd1);
    checkOutput("t1_wb_dst0", 64'(wb_dst[0]), 64'd5);
    checkOutput("t1_wb_val0", 64'(wb_val[0]), 64'hDEADBEEF);
    checkOutput("t1_wb_fu_id0", 64'(wb_fu_id[0]), 64'd1);
    checkOutput("t1_wb_valid1", 64'(wb_valid[1]), 64'd0);
    idle(2);

    $display("[TB] port contention");
    for (int i = 0; i < NUM_FUS; i++) begin
      d[i] = REG_AW'(i + 1);
      x[i] = $urandom;
    end
    applyStimulus('1, d, x, 1'b0);
    idle(3);

    $display("[TB] continuous back-pressure fairness");
    applyStimulus('1, d, x, 1'b0);
    count_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NUM_FUS; i++) x[i] = $urandom;
      applyStimulus('1, d, x, 1'b0);
    end
    count_en = 1'b0;
    for (int i = 0; i < NUM_FUS; i++)
      checkOutput($sformatf("fair_grants_fu%0d", i), 64'(grant_cnt[i]), 64'd20);
    idle(3);

    $display("[TB] same-destination conflict");
    d = '0; x = '0;
    d[0] = 7; x[0] = 32'h11;
    d[1] = 7; x[1] = 32'h22;
    applyStimulus(4'b0011, d, x, 1'b0);
    idle(3);

    $display("[TB] x0 result and flush");
    d = '0; x = '0; x[2] = 32'hCAFE;
    applyStimulus(4'b0100, d, x, 1'b0);
    idle(1);
    d[0] = 3; d[1] = 4; d[3] = 5;
    x[0] = 32'hA0; x[1] = 32'hA1; x[3] = 32'hA3;
    applyStimulus(4'b1011, d, x, 1'b0);
    applyStimulus('1, d, x, 1'b1);
    idle(2);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < NUM_FUS; i++) begin
      d[i] = REG_AW'(i + 9);
      x[i] = $urandom;
    end
    applyStimulus('1, d, x, 1'b0);
    checkOutput("pre_reset_wb_valid", 64'(wb_valid), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("async_reset_fu_ready", 64'(fu_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fu_valid = '0;
    modelReset();
    idle(3);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_FUS; i++) begin
        d[i] = REG_AW'($urandom_range(0, 7));
        x[i] = $urandom;
      end
      applyStimulus(NUM_FUS'($urandom), d, x, ($urandom_range(0, 15) == 0));
    end
    idle(4);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
